// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: decode-stage issue controller for the 5-stage RV32I pipeline.
// Decides each cycle whether the decode instruction issues, stalls on a RAW
// hazard, or is discarded. Tracks destination registers in flight and counts
// hazard-stall cycles with a saturating counter.
// Optional feature macro: FORWARDING_EN (defined = bypass network present,
// only load-use in EX stalls; undefined = stall on any match in EX or MEM).
module decode_issue_ctrl #(
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [6:0]             opcode,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    input  logic [4:0]             rd,
    input  logic                   hold,
    input  logic                   flush,
    output logic                   issue_valid,
    output logic                   stall,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

`ifdef FORWARDING_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } trk_t;

    // The WB slot is never consulted by either hazard rule (the register file
    // writes before it reads), so only EX and MEM are kept in flops.
    trk_t ex_e, mem_e;
    trk_t new_ex;

    logic uses_rs1, uses_rs2, writes_rd, is_load;
    logic ex_hit, mem_hit, hazard;

    // Entry matches when valid, load-qualified if required, and rd hits a used source.
    function automatic logic match(trk_t e, logic need_ld, logic u1, logic u2,
                                   logic [4:0] s1, logic [4:0] s2);
        return e.v && (e.rd != 5'd0) && (!need_ld || e.ld) &&
               ((u1 && (e.rd == s1)) || (u2 && (e.rd == s2)));
    endfunction

    // Opcode classification; unknown opcodes use and write nothing.
    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        is_load   = (opcode == OP_LOAD);
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
            OP_JALR, OP_LOAD, OP_IMM: begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
            OP_OP:     begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
            OP_BRANCH, OP_STORE: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            default: ;
        endcase
        if (rd == 5'd0) writes_rd = 1'b0;
    end

    // Hazard detection: load-use in EX with bypass, else any EX/MEM match.
    always_comb begin
        ex_hit  = match(ex_e, FWD, uses_rs1, uses_rs2, rs1, rs2);
        mem_hit = match(mem_e, 1'b0, uses_rs1, uses_rs2, rs1, rs2);
        hazard  = ex_hit | (~FWD & mem_hit);
    end

    // Issue decision, priority hold > flush > hazard > issue.
    always_comb begin
        in_ready    = 1'b0;
        issue_valid = 1'b0;
        stall       = 1'b0;
        if (hold) begin
            in_ready = 1'b0;
        end else if (flush) begin
            in_ready = 1'b1;
        end else if (in_valid && hazard) begin
            stall = 1'b1;
        end else if (in_valid) begin
            in_ready    = 1'b1;
            issue_valid = 1'b1;
        end
        new_ex = '0;
        if (issue_valid && writes_rd) new_ex = '{v: 1'b1, rd: rd, ld: is_load};
    end

    // Tracker shift and saturating stall counter; frozen while hold is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_e        <= '0;
            mem_e       <= '0;
            stall_count <= '0;
        end else if (!hold) begin
            ex_e  <= new_ex;
            mem_e <= ex_e;
            if (stall && (stall_count != {STALL_CNT_W{1'b1}}))
                stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Bench for decode_issue_ctrl: directed scenarios then randomized traffic,
// checked against a history-based reference model through a scoreboard queue.
module tb_decode_issue_ctrl;
    localparam int W = 4;
    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011, IMM = 7'b0010011, OPR = 7'b0110011;
    localparam logic [6:0] UNK = 7'b1111111;

    logic clk = 1'b0;
    logic reset, in_valid, hold, flush, in_ready, issue_valid, stall;
    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd;
    logic [W-1:0] stall_count;

    always #5 clk = ~clk;

    decode_issue_ctrl #(.STALL_CNT_W(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd), .hold(hold), .flush(flush),
        .issue_valid(issue_valid), .stall(stall), .stall_count(stall_count)
    );

    typedef struct packed {
        logic         chk;
        logic         rdy;
        logic         iv;
        logic         st;
        logic [W-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;

    // Reference model: a log of what each advancing cycle wrote (0 = nothing),
    // indexed by an advancing-cycle number. Distance d back = d stages ahead.
    int t = 0;
    int hist_rd[int];
    bit hist_ld[int];
    int m_cnt = 0;

    function automatic bit f_u1(logic [6:0] op);
        return op inside {JALR, LD, IMM, BR, ST, OPR};
    endfunction
    function automatic bit f_u2(logic [6:0] op);
        return op inside {BR, ST, OPR};
    endfunction
    function automatic bit f_wr(logic [6:0] op);
        return op inside {LUI, AUIPC, JAL, JALR, LD, IMM, OPR};
    endfunction

    function automatic bit m_hazard(logic [6:0] op, logic [4:0] a, logic [4:0] b);
        bit h = 0;
`ifdef FORWARDING_EN
        int dmax = 1;
`else
        int dmax = 2;
`endif
        for (int d = 1; d <= dmax; d++) begin
            int k = t - d;
            if (hist_rd.exists(k) && hist_rd[k] != 0) begin
`ifdef FORWARDING_EN
                if (hist_ld[k] &&
                    ((f_u1(op) && int'(a) == hist_rd[k]) || (f_u2(op) && int'(b) == hist_rd[k])))
                    h = 1;
`else
                if ((f_u1(op) && int'(a) == hist_rd[k]) || (f_u2(op) && int'(b) == hist_rd[k]))
                    h = 1;
`endif
            end
        end
        return h;
    endfunction

    // Drive one cycle, push the model's expectation, then advance the model.
    task automatic step(input bit v, input logic [6:0] op, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d, input bit h,
                        input bit f, input bit r, output bit rdy);
        exp_t e;
        @(posedge clk); #1;
        in_valid = v; opcode = op; rs1 = a; rs2 = b; rd = d;
        hold = h; flush = f; reset = r;
        e = '0;
        e.chk = !r;
        e.cnt = W'(m_cnt);
        if (h) e.rdy = 0;
        else if (f) e.rdy = 1;
        else if (v && m_hazard(op, a, b)) e.st = 1;
        else if (v) begin e.rdy = 1; e.iv = 1; end
        q.push_back(e);
        rdy = e.rdy;
        if (r) begin
            hist_rd.delete(); hist_ld.delete(); m_cnt = 0;
        end else if (!h) begin
            hist_rd[t] = (e.iv && f_wr(op) && d != 0) ? int'(d) : 0;
            hist_ld[t] = (op == LD);
            t++;
            if (e.st && m_cnt < (1 << W) - 1) m_cnt++;
        end
    endtask

    task automatic idle(input int n);
        bit r;
        for (int i = 0; i < n; i++) step(0, 7'd0, 0, 0, 0, 0, 0, 0, r);
    endtask

    // Present an instruction until the model says it was consumed (bounded).
    task automatic issue(input logic [6:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d);
        bit r;
        int n = 0;
        do begin
            step(1, op, a, b, d, 0, 0, 0, r);
            n++;
        end while (!r && n < 10);
    endtask

    // Monitor: compare DUT outputs against the oldest expectation each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk) begin
                checks += 4;
                if (in_ready !== e.rdy) begin errors++;
                    $display("FAIL in_ready t=%0t got %b exp %b", $time, in_ready, e.rdy); end
                if (issue_valid !== e.iv) begin errors++;
                    $display("FAIL issue_valid t=%0t got %b exp %b", $time, issue_valid, e.iv); end
                if (stall !== e.st) begin errors++;
                    $display("FAIL stall t=%0t got %b exp %b", $time, stall, e.st); end
                if (stall_count !== e.cnt) begin errors++;
                    $display("FAIL stall_count t=%0t got %0d exp %0d", $time, stall_count, e.cnt); end
            end
        end
    end

    initial begin
        bit r;
        logic [6:0] ops [10];
        logic [6:0] p_op;
        logic [4:0] p_a, p_b, p_d;
        bit pend;
        ops = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, IMM, OPR, UNK};
        reset = 1; in_valid = 0; hold = 0; flush = 0; opcode = 0; rs1 = 0; rs2 = 0; rd = 0;

        step(0, 7'd0, 0, 0, 0, 0, 0, 1, r);
        step(0, 7'd0, 0, 0, 0, 0, 0, 1, r);
        idle(1);
        issue(OPR, 1, 2, 3);                 // ADD x3,x1,x2
        idle(2);
        issue(LD, 1, 0, 5);                  // LW x5
        issue(OPR, 5, 1, 6);                 // ADD x6,x5,x1 -> load-use
        idle(3);
        issue(IMM, 0, 0, 7);                 // ADDI x7,x0,1
        issue(OPR, 7, 7, 8);                 // ADD x8,x7,x7
        idle(3);
        issue(LD, 1, 0, 0);                  // LW x0
        issue(OPR, 0, 0, 1);                 // ADD x1,x0,x0 (x0 never matches)
        issue(LUI, 0, 0, 9);
        issue(JAL, 9, 9, 1);
        idle(3);
        // flush while a hazard is pending
        issue(LD, 2, 0, 10);
        step(1, OPR, 10, 0, 11, 0, 1, 0, r);
        idle(3);
        // hold for 3 cycles over a pending hazard, then let it resolve
        issue(LD, 2, 0, 12);
        for (int i = 0; i < 3; i++) step(1, OPR, 12, 12, 13, 1, 0, 0, r);
        issue(OPR, 12, 12, 13);
        idle(3);
        // drive the 4-bit counter past saturation
        for (int i = 0; i < 20; i++) begin
            issue(LD, 1, 0, 14);
            issue(OPR, 14, 14, 15);
        end
        idle(2);
        // reset in the middle of a stall, then the dependent instruction issues at once
        issue(LD, 1, 0, 16);
        step(1, OPR, 16, 1, 17, 0, 0, 0, r);
        step(1, OPR, 16, 1, 17, 1, 1, 1, r);
        issue(OPR, 16, 1, 17);
        idle(2);

        // randomized traffic with a small register window to provoke hazards
        pend = 0; p_op = 0; p_a = 0; p_b = 0; p_d = 0;
        for (int i = 0; i < 2000; i++) begin
            bit v, h, f, rs;
            if (!pend && $urandom_range(0, 9) < 8) begin
                pend = 1;
                p_op = ops[$urandom_range(0, 9)];
                p_a = 5'($urandom_range(0, 7));
                p_b = 5'($urandom_range(0, 7));
                p_d = 5'($urandom_range(0, 7));
            end
            v  = pend;
            h  = ($urandom_range(0, 99) < 10);
            f  = ($urandom_range(0, 99) < 6);
            rs = ($urandom_range(0, 199) < 2);
            step(v, p_op, p_a, p_b, p_d, h, f, rs, r);
            if (r || rs) pend = 0;
        end
        idle(2);
        @(negedge clk); #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left %0d exp 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
